// File: rtl/reaction_timer_fsm.sv
// rtl/reaction_timer_fsm.sv - reaction-timer controller: random delay, go window, capture/timeout/false-start
// Optional best-time tracking enabled by defining REACTION_TIMER_BEST_TIME_EN.
module reaction_timer_fsm #(
  parameter int CNT_W     = 32,
  parameter int MIN_DELAY = 4,
  parameter int TIMEOUT   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ss,
  input  logic [CNT_W-1:0] cnt,
  output logic             go,
  output logic             capture,
  output logic [CNT_W-1:0] elapsed,
  output logic             false_start,
  output logic             timeout,
  output logic             busy
`ifdef REACTION_TIMER_BEST_TIME_EN
  ,
  output logic [CNT_W-1:0] best_time
`endif
);

  typedef enum logic [2:0] {IDLE, DELAY, GO, DONE, FAULT} state_t;

  localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DELAY);
  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic             ss_q;
  logic             press;
  logic [CNT_W-1:0] dly;
  logic [CNT_W-1:0] elapsed_inc;
  logic             expire;
  logic             limit;

  assign press       = ss & ~ss_q;
  assign elapsed_inc = elapsed + ONE;
  // dly holds the cycles still to wait, so the last DELAY edge sees 1
  assign expire      = (dly == ONE);
  assign limit       = (elapsed == TMO - ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, FAULT: if (press) state_nxt = DELAY;
      DELAY: begin
        if (press)       state_nxt = FAULT;
        else if (expire) state_nxt = GO;
      end
      GO:      if (press || limit) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    go   = (state == GO);
    busy = (state == DELAY) || (state == GO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_q        <= 1'b0;
      dly         <= '0;
      elapsed     <= '0;
      capture     <= 1'b0;
      false_start <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      ss_q    <= ss;
      capture <= 1'b0;
      case (state)
        IDLE, DONE, FAULT: begin
          if (press) begin
            dly         <= (cnt < MIN_D) ? MIN_D : cnt;
            elapsed     <= '0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        DELAY: begin
          dly <= dly - ONE;
          if (press) false_start <= 1'b0 | 1'b1;
        end
        GO: begin
          elapsed <= elapsed_inc;
          // a press on the timeout edge wins, so timeout only fires without one
          if (press)      capture <= 1'b1;
          else if (limit) timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef REACTION_TIMER_BEST_TIME_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_time <= '1;
    end else if ((state == GO) && press && (elapsed_inc < best_time)) begin
      best_time <= elapsed_inc;
    end
  end
`endif

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// tb/tb_reaction_timer_fsm.sv - directed self-checking bench for reaction_timer_fsm
module tb_reaction_timer_fsm;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             ss;
  logic [CNT_W-1:0] cnt;
  logic             go;
  logic             capture;
  logic [CNT_W-1:0] elapsed;
  logic             false_start;
  logic             timeout;
  logic             busy;
`ifdef REACTION_TIMER_BEST_TIME_EN
  logic [CNT_W-1:0] best_time;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  reaction_timer_fsm #(.CNT_W(CNT_W), .MIN_DELAY(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .ss          (ss),
    .cnt         (cnt),
    .go          (go),
    .capture     (capture),
    .elapsed     (elapsed),
    .false_start (false_start),
    .timeout     (timeout),
    .busy        (busy)
`ifdef REACTION_TIMER_BEST_TIME_EN
    ,
    .best_time   (best_time)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int d);
    cnt = CNT_W'(d);
    ss  = 1'b1;
    tick();
    ss  = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_fs_clr", 32'(false_start), 32'd0);
    check("start_to_clr", 32'(timeout), 32'd0);
  endtask

  task automatic wait_go(input string tag, input int exp_d);
    int n = 0;
    while (!go && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp_d));
    check("go_elapsed0", 32'(elapsed), 32'd0);
  endtask

  task automatic react(input string tag, input int k);
    for (int i = 1; i < k; i++) tick();
    ss = 1'b1;
    tick();
    ss = 1'b0;
    check({tag, "_capture"}, 32'(capture), 32'd1);
    check({tag, "_elapsed"}, 32'(elapsed), 32'(k));
    check({tag, "_go"}, 32'(go), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    tick();
    check({tag, "_cap_pulse"}, 32'(capture), 32'd0);
  endtask

  initial begin
    int n;
    logic seen;

    // reset with ss toggling
    reset = 1'b0;
    ss    = 1'b0;
    cnt   = '0;
    for (int i = 0; i < 3; i++) begin
      ss = ~ss;
      tick();
    end
    check("rst_go", 32'(go), 32'd0);
    check("rst_capture", 32'(capture), 32'd0);
    check("rst_fs", 32'(false_start), 32'd0);
    check("rst_to", 32'(timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_elapsed", 32'(elapsed), 32'd0);
`ifdef REACTION_TIMER_BEST_TIME_EN
    check("rst_best", 32'(best_time), 32'hFFFF);
`endif
    ss    = 1'b0;
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (go || busy) seen = 1'b1;
    end
    check("idle_quiet", 32'(seen), 32'd0);

    // normal round
    start(20);
    wait_go("normal_delay", 20);
    react("normal", 7);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (elapsed != 7 || go || busy) seen = 1'b1;
    end
    check("normal_hold", 32'(seen), 32'd0);

    // minimum delay clamp
    start(2);
    wait_go("clamp_delay", 4);
    react("clamp", 3);

    // false start
    start(50);
    for (int i = 1; i < 10; i++) tick();
    ss = 1'b1;
    tick();
    ss = 1'b0;
    check("fs_flag", 32'(false_start), 32'd1);
    check("fs_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (go) seen = 1'b1;
    end
    check("fs_no_go", 32'(seen), 32'd0);
    check("fs_held", 32'(false_start), 32'd1);
    start(20);
    wait_go("fs_restart_delay", 20);

    // timeout from this GO window
    n = 1;
    seen = 1'b0;
    while (go && n < 100) begin
      tick();
      if (capture) seen = 1'b1;
      if (go) n++;
    end
    check("to_go_cycles", 32'(n), 32'd16);
    check("to_flag", 32'(timeout), 32'd1);
    check("to_elapsed", 32'(elapsed), 32'd16);
    check("to_no_capture", 32'(seen), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
    tick();
    check("to_elapsed_hold", 32'(elapsed), 32'd16);

    // press exactly on the timeout edge
    start(5);
    wait_go("to_edge_delay", 5);
    react("to_edge", 16);

    // reset asserted between edges during GO
    start(10);
    wait_go("rst_mid_delay", 10);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("rstmid_go", 32'(go), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_elapsed", 32'(elapsed), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // best-time rounds
    start(8);
    wait_go("best1_delay", 8);
    react("best1", 7);
`ifdef REACTION_TIMER_BEST_TIME_EN
    check("best1", 32'(best_time), 32'd7);
`endif
    start(8);
    wait_go("best2_delay", 8);
    react("best2", 12);
`ifdef REACTION_TIMER_BEST_TIME_EN
    check("best2", 32'(best_time), 32'd7);
`endif
    start(8);
    wait_go("best3_delay", 8);
    react("best3", 5);
`ifdef REACTION_TIMER_BEST_TIME_EN
    check("best3", 32'(best_time), 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_timer_fsm.md
Name: reaction_timer_fsm

Overview:
Parametrised reaction-timer controller, successor to the fixed 32-bit start/stop FSM. A start press on `ss` loads a random delay from `cnt`. When the delay expires the block raises `go`, then counts cycles until the next press and captures that reaction time. It adds a minimum delay clamp, false-start detection, a timeout with saturation, and a held result. It sits between the debounced button and the LFSR on one side, and the display/scoreboard logic on the other.

Parameters:
- CNT_W, 32: width of `cnt`, the delay counter and `elapsed`.
- MIN_DELAY, 4: minimum random delay in cycles; must be ≥1.
- TIMEOUT, 1000: maximum reaction count in cycles; must be < 2^CNT_W.

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- ss, input, 1: start/stop button level, already synchronous and debounced.
- cnt, input, CNT_W: random delay value, sampled only on a start edge.
- go, output, 1: high while the player should react.
- capture, output, 1: one-cycle pulse when a reaction is captured.
- elapsed, output, CNT_W: reaction cycles; live during GO, held afterwards.
- false_start, output, 1: press occurred during DELAY; held until the next start.
- timeout, output, 1: no press within TIMEOUT cycles; held until the next start.
- busy, output, 1: high in DELAY or GO.
- best_time, output, CNT_W: present only with BEST_TIME_EN.

Behaviour:
- Press detection: `ss_q` registers `ss`. A press is `ss & ~ss_q`. A held `ss` gives exactly one press.
- Reset (reset=0, asynchronous):
  - state = IDLE.
  - go, capture, false_start, timeout, busy = 0.
  - elapsed = 0, delay counter = 0, ss_q = 0.
- States: IDLE, DELAY, GO, DONE, FAULT. Default branch returns to IDLE.
- IDLE/DONE/FAULT + press at edge T:
  - Load delay D = (cnt < MIN_DELAY) ? MIN_DELAY : cnt.
  - Clear elapsed, false_start and timeout; set busy; next state DELAY.
  - With no press, the state and all held outputs are unchanged.
- DELAY:
  - Delay counter decrements every cycle.
  - `go` rises at edge T+D; elapsed = 0 at that edge; next state GO.
  - Press in DELAY: next state FAULT, false_start=1, busy=0, go never asserts.
  - Press on the same edge the delay expires counts as a false start (false start has priority).
- GO:
  - elapsed increments every edge, so elapsed = number of cycles `go` has been high.
  - Press at edge T+D+k:
    - elapsed = k, go=0, capture=1 for exactly one cycle, busy=0, next state DONE.
  - No press and elapsed reaches TIMEOUT:
    - go=0, timeout=1, busy=0, elapsed=TIMEOUT (saturated), next state DONE.
  - Press on the timeout edge: treated as a valid capture; timeout stays 0; elapsed=TIMEOUT.
- DONE/FAULT: elapsed, false_start and timeout hold until the next press restarts the sequence.
- Invariants:
  - capture and go are never high together.
  - elapsed never exceeds TIMEOUT.
  - Reset in any state, including mid-GO, forces the reset values immediately without waiting for a clock edge.

Optional Feature:
- Macro: REACTION_TIMER_BEST_TIME_EN.
- When defined:
  - Adds the `best_time` output, reset to all-ones.
  - On each capture pulse (not on timeout or false start), best_time <= min(best_time, new elapsed), updated on the same edge as the capture pulse.
  - Cleared only by reset.
- When undefined: no port and no register; all other behaviour is identical.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with ss toggling → all outputs 0 and elapsed=0. Release with ss=0 for 10 cycles → go stays 0, busy stays 0.
2. Normal round: cnt=20, press at edge T, press again 7 cycles after go rises → go rises at T+20; capture high for 1 cycle; elapsed=7; go=0; busy=0; elapsed held at 7 for 20 further cycles.
3. Minimum clamp: cnt=2, press at T → go rises at T+4 (MIN_DELAY), not T+2.
4. False start: cnt=50, press at T+10 → false_start=1 at T+10; go never asserts. Next press with cnt=20 → false_start clears; go rises 20 cycles later.
5. Timeout (TIMEOUT=16), no press in GO → go high for exactly 16 cycles; timeout=1; elapsed=16; capture never pulses. Press on the 16th edge instead → capture=1, timeout=0, elapsed=16.
6. Reset mid-GO and best time:
   - reset=0 asserted between clock edges while go=1 → go=0 and busy=0 without waiting for a clock edge.
   - With REACTION_TIMER_BEST_TIME_EN, rounds of 7, 12 and 5 cycles → best_time reads 7, 7, 5.
